matrix_scale_div: RTL and testbench
===================================

Name: matrix_scale_div

Overview:
- Divides every element of a ROWS x COLS signed integer matrix by one signed scalar divisor.
- Produces fixed-point quotients with FBITS fractional bits.
- Uses LANES parallel bit-serial restoring dividers, so throughput is a build-time trade-off.
- Sits in the attention path after the score matmul (scaling by sqrt(d_k)) and replaces the single-divider, integer-only scaler.
- Adds signed divisors, fractional output, saturation and divide-by-zero handling.

Parameters:
- ROWS, 3, matrix rows.
- COLS, 3, matrix columns.
- WIDTH, 16, bit width of matrix_in and matrix_out elements (two's complement).
- DIVISOR_WIDTH, 8, bit width of divisor (two's complement, 1 <= DIVISOR_WIDTH <= WIDTH).
- FBITS, 0, fractional bits in the result, 0 <= FBITS < WIDTH.
- LANES, 4, parallel divider lanes, 1 <= LANES <= ROWS*COLS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- matrix_in  in  signed [WIDTH-1:0] [ROWS][COLS]  dividend matrix.
- divisor  in  signed [DIVISOR_WIDTH-1:0]  scalar divisor.
- matrix_out  out  signed [WIDTH-1:0] [ROWS][COLS]  result matrix.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when all elements are written.
- dbz  out  1  divisor was zero in the last operation.
- ovf  out  1  at least one element saturated in the last operation.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset (including mid-operation):
  - state goes to IDLE.
  - Every matrix_out element, busy, done, dbz and ovf go to 0.
  - Any in-flight division is discarded.
- Snapshot: when start=1 in IDLE, matrix_in and divisor are latched into internal registers. Inputs may change afterwards without effect. Also on acceptance: dbz and ovf clear, done clears.
- start while busy=1 is ignored. There is no queuing.
- Element order: row-major, linear index k = r*COLS + c.
  - Group g covers k = g*LANES .. g*LANES+LANES-1.
  - G = ceil(ROWS*COLS/LANES).
  - Lanes whose k >= ROWS*COLS in the last group are ignored and write nothing.
- Arithmetic per element, with divisor sign-extended to WIDTH:
  - q = trunc_toward_zero(a * 2^FBITS / b).
  - Computed on magnitudes with a restoring divider, one quotient bit per cycle, ITER = WIDTH + FBITS iterations.
  - Sign = sign(a) XOR sign(b); a zero quotient is 0, never negative zero.
- Saturation: if q > 2^(WIDTH-1)-1, the output is 2^(WIDTH-1)-1; if q < -2^(WIDTH-1), the output is -2^(WIDTH-1). Either case sets ovf (sticky for the operation).
- Divide by zero (latched divisor == 0):
  - No iterations run.
  - Each element becomes +max if a >= 0, or -max-1 if a < 0.
  - dbz=1. ovf is not set.
- State machine:
  - IDLE: on start, go to LOAD with group=0.
  - LOAD: load the lanes from group g and clear the iteration counter. Go to DIVIDE, or to STORE if dbz.
  - DIVIDE: one iteration per cycle. After iteration ITER-1, go to STORE.
  - STORE: write the group's results into matrix_out. If g == G-1, set done=1 for one cycle and return to IDLE. Otherwise g increments and the block goes to LOAD.
- Latency (start sampled at edge 0):
  - done is high in the cycle after edge G*(ITER+2).
  - dbz case: after edge G*2.
  - busy goes high the cycle after start and falls with done.
- Output holding:
  - matrix_out elements not yet written in the current operation keep their previous values.
  - All results, dbz and ovf hold until reset or the next accepted start.

Test Plan:
- Defaults (3x3, WIDTH=16, FBITS=0, LANES=4); matrix_in = 10..90 step 10; divisor = 3:
  - out = 3,6,10,13,16,20,23,26,30.
  - done exactly 54 cycles after start (G=3, ITER=16). busy high throughout. dbz=0, ovf=0.
- Signs: matrix_in = {-7, 7, -7, 0, ...}; divisor = -2:
  - out = 3, -3, 3, 0, ... (truncation toward zero).
- Fraction: FBITS=8; a=1, b=3 -> 85 (0x0055). a=-1, b=3 -> -85.
- Saturation:
  - a = -32768, b = -1 -> 32767, ovf=1.
  - FBITS=8, a=200, b=1 -> 32767, ovf=1.
- Divide by zero: divisor=0 with a mix of signs -> positives give 32767, negatives give -32768. dbz=1, done after G*2 cycles.
- Control:
  - Pulse start mid-operation: ignored, result unchanged.
  - Assert reset during DIVIDE: outputs and flags become 0 next cycle, busy=0.
  - A fresh start afterwards completes normally.
  - LANES=1 and LANES=9 builds give identical results, with latencies 9*18 and 1*18.

Source files
------------

// File: rtl/matrix_scale_div_if.sv
// Bus between the attention-path controller and the matrix scaler: request,
// operands, result matrix and status flags.
interface matrix_scale_div_if #(
    parameter int ROWS          = 3,
    parameter int COLS          = 3,
    parameter int WIDTH         = 16,
    parameter int DIVISOR_WIDTH = 8
);
    logic                            start;
    logic signed [WIDTH-1:0]         matrix_in  [ROWS][COLS];
    logic signed [DIVISOR_WIDTH-1:0] divisor;
    logic signed [WIDTH-1:0]         matrix_out [ROWS][COLS];
    logic                            busy;
    logic                            done;
    logic                            dbz;
    logic                            ovf;

    modport master (
        output start, matrix_in, divisor,
        input  matrix_out, busy, done, dbz, ovf
    );

    modport slave (
        input  start, matrix_in, divisor,
        output matrix_out, busy, done, dbz, ovf
    );
endinterface

// File: rtl/matrix_scale_div.sv
// Divides a ROWS x COLS signed matrix by a signed scalar using LANES bit-serial
// restoring dividers, producing saturated fixed-point quotients with FBITS fraction bits.
module matrix_scale_div #(
    parameter int ROWS          = 3,
    parameter int COLS          = 3,
    parameter int WIDTH         = 16,
    parameter int DIVISOR_WIDTH = 8,
    parameter int FBITS         = 0,
    parameter int LANES         = 4
) (
    input logic               clk,
    input logic               reset,
    matrix_scale_div_if.slave bus
);
    localparam int N    = ROWS * COLS;
    localparam int G    = (N + LANES - 1) / LANES;
    localparam int NPAD = G * LANES;
    localparam int ITER = WIDTH + FBITS;
    localparam int CW   = $clog2(ITER + 1);
    localparam int GW   = $clog2(G + 1);
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, STORE} state_t;

    state_t                  state;
    logic [GW-1:0]           grp;
    logic [CW-1:0]           cnt;
    logic                    busy_q, done_q, dbz_q, ovf_q;
    logic signed [WIDTH-1:0] out_q [ROWS][COLS];

    logic signed [WIDTH-1:0] a_snap [NPAD];
    logic [WIDTH-1:0]        b_mag;
    logic                    b_neg;
    logic signed [WIDTH-1:0] b_ext;
    logic [WIDTH-1:0]        rem [LANES];
    logic [ITER-1:0]         dvd [LANES];
    logic                    a_neg [LANES];

    logic signed [WIDTH-1:0] ld_a [LANES];
    logic [WIDTH-1:0]        ld_mag [LANES];
    logic                    lane_vld [LANES];
    logic [WIDTH:0]          sat_res [LANES];
    logic signed [WIDTH-1:0] res [LANES];
    logic                    any_sat;

    // Map a quotient magnitude plus sign into range; MSB of the result flags clipping.
    function automatic logic [WIDTH:0] saturate(input logic [ITER-1:0] qmag, input logic neg);
        logic [ITER-1:0] lim;
        logic [ITER-1:0] qneg;
        lim  = ITER'(1) << (WIDTH - 1);
        qneg = -qmag;
        if (neg) begin
            if (qmag > lim) return {1'b1, SMIN};
            return {1'b0, qneg[WIDTH-1:0]};
        end
        if (qmag >= lim) return {1'b1, SMAX};
        return {1'b0, qmag[WIDTH-1:0]};
    endfunction

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    function automatic logic [WIDTH+ITER-1:0] div_step(input logic [WIDTH-1:0] r,
                                                       input logic [ITER-1:0] d,
                                                       input logic [WIDTH-1:0] bmag);
        logic [WIDTH:0] trial;
        logic           qbit;
        trial = {r, d[ITER-1]};
        qbit  = (trial >= {1'b0, bmag});
        if (qbit) trial = trial - {1'b0, bmag};
        return {trial[WIDTH-1:0], d[ITER-2:0], qbit};
    endfunction

    assign b_ext = WIDTH'(bus.divisor);

    always_comb begin
        any_sat = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            ld_a[l] = '0;
            for (int gg = 0; gg < G; gg++)
                if (grp == GW'(gg)) ld_a[l] = a_snap[gg*LANES + l];
            ld_mag[l]   = ld_a[l][WIDTH-1] ? -ld_a[l] : ld_a[l];
            lane_vld[l] = (int'(grp) * LANES + l) < N;
            sat_res[l]  = saturate(dvd[l], a_neg[l] ^ b_neg);
            res[l]      = dbz_q ? (a_neg[l] ? SMIN : SMAX) : sat_res[l][WIDTH-1:0];
            if (lane_vld[l] && !dbz_q && sat_res[l][WIDTH]) any_sat = 1'b1;
        end
    end

    // Datapath: operand snapshot and lane dividers carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    a_snap[r*COLS + c] <= bus.matrix_in[r][c];
            for (int k = N; k < NPAD; k++) a_snap[k] <= '0;
            b_mag <= b_ext[WIDTH-1] ? -b_ext : b_ext;
            b_neg <= b_ext[WIDTH-1];
        end
        for (int l = 0; l < LANES; l++) begin
            if (state == LOAD) begin
                rem[l]   <= '0;
                dvd[l]   <= ITER'(ld_mag[l]) << FBITS;
                a_neg[l] <= ld_a[l][WIDTH-1];
            end else if (state == DIVIDE) begin
                {rem[l], dvd[l]} <= div_step(rem[l], dvd[l], b_mag);
            end
        end
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grp    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    out_q[r][c] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state  <= LOAD;
                    grp    <= '0;
                    busy_q <= 1'b1;
                    dbz_q  <= 1'b0;
                    ovf_q  <= 1'b0;
                end
                LOAD: begin
                    cnt   <= '0;
                    dbz_q <= (b_mag == '0);
                    state <= (b_mag == '0) ? STORE : DIVIDE;
                end
                DIVIDE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= STORE;
                end
                STORE: begin
                    for (int e = 0; e < N; e++)
                        if (grp == GW'(e / LANES)) out_q[e / COLS][e % COLS] <= res[e % LANES];
                    if (any_sat) ovf_q <= 1'b1;
                    if (grp == GW'(G - 1)) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        grp   <= grp + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.matrix_out = out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.dbz        = dbz_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_matrix_scale_div.sv
// Bench for matrix_scale_div: four builds (default, FBITS=8, LANES=1, LANES=9) run the
// same operations and are compared against a plain-arithmetic reference.
module tb_matrix_scale_div;
    localparam int R  = 3;
    localparam int C  = 3;
    localparam int W  = 16;
    localparam int DW = 8;
    typedef logic signed [W-1:0] mat_t [R][C];

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    mat_t                  min;
    logic signed [DW-1:0]  div;

    always #5 clk = ~clk;

    matrix_scale_div_if #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW)) if_a ();
    matrix_scale_div_if #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW)) if_f ();
    matrix_scale_div_if #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW)) if_1 ();
    matrix_scale_div_if #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW)) if_9 ();

    matrix_scale_div #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW), .FBITS(0), .LANES(4))
        dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    matrix_scale_div #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW), .FBITS(8), .LANES(4))
        dut_f (.clk(clk), .reset(reset), .bus(if_f.slave));
    matrix_scale_div #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW), .FBITS(0), .LANES(1))
        dut_1 (.clk(clk), .reset(reset), .bus(if_1.slave));
    matrix_scale_div #(.ROWS(R), .COLS(C), .WIDTH(W), .DIVISOR_WIDTH(DW), .FBITS(0), .LANES(9))
        dut_9 (.clk(clk), .reset(reset), .bus(if_9.slave));

    assign if_a.start = start;  assign if_a.matrix_in = min;  assign if_a.divisor = div;
    assign if_f.start = start;  assign if_f.matrix_in = min;  assign if_f.divisor = div;
    assign if_1.start = start;  assign if_1.matrix_in = min;  assign if_1.divisor = div;
    assign if_9.start = start;  assign if_9.matrix_in = min;  assign if_9.divisor = div;

    mat_t out_m [4];
    logic done_v [4], busy_v [4], dbz_v [4], ovf_v [4];
    assign out_m[0] = if_a.matrix_out; assign done_v[0] = if_a.done; assign busy_v[0] = if_a.busy;
    assign out_m[1] = if_f.matrix_out; assign done_v[1] = if_f.done; assign busy_v[1] = if_f.busy;
    assign out_m[2] = if_1.matrix_out; assign done_v[2] = if_1.done; assign busy_v[2] = if_1.busy;
    assign out_m[3] = if_9.matrix_out; assign done_v[3] = if_9.done; assign busy_v[3] = if_9.busy;
    assign dbz_v[0] = if_a.dbz; assign dbz_v[1] = if_f.dbz; assign dbz_v[2] = if_1.dbz; assign dbz_v[3] = if_9.dbz;
    assign ovf_v[0] = if_a.ovf; assign ovf_v[1] = if_f.ovf; assign ovf_v[2] = if_1.ovf; assign ovf_v[3] = if_9.ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int lat [4];
    bit busy_ok [4];
    bit pulse_ok [4];

    function automatic int fbits_of(int i);
        return (i == 1) ? 8 : 0;
    endfunction

    function automatic int lanes_of(int i);
        case (i)
            2:       return 1;
            3:       return 9;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_lat(int i, int b);
        int g;
        g = (R*C + lanes_of(i) - 1) / lanes_of(i);
        return (b == 0) ? 2*g : g * (W + fbits_of(i) + 2);
    endfunction

    // a * 2^fb / b truncated toward zero, clamped to the signed W-bit range.
    function automatic int ref_q(int a, int b, int fb, output bit sat);
        longint q;
        sat = 1'b0;
        if (b == 0) return (a < 0) ? -32768 : 32767;
        q = (longint'(a) * (longint'(1) << fb)) / longint'(b);
        if (q > 32767)  begin sat = 1'b1; q = 32767;  end
        if (q < -32768) begin sat = 1'b1; q = -32768; end
        return int'(q);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input mat_t m, input int b, input int pulse_at);
        bit seen [4];
        for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0; lat[i] = -1; busy_ok[i] = 1'b1; pulse_ok[i] = 1'b1;
        end
        @(negedge clk);
        min = m; div = DW'(b); start = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (n == 0) begin
                for (int r = 0; r < R; r++)
                    for (int c = 0; c < C; c++) min[r][c] = W'($urandom);
                div = DW'($urandom);
            end
            if (n == pulse_at) start = 1'b1;
            else if (n == 0 || n == pulse_at + 1) start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (seen[i]) begin
                    if (n == lat[i] + 1 && done_v[i] !== 1'b0) pulse_ok[i] = 1'b0;
                end else if (done_v[i] === 1'b1) begin
                    seen[i] = 1'b1; lat[i] = n;
                    if (busy_v[i] !== 1'b0) busy_ok[i] = 1'b0;
                end else if (busy_v[i] !== 1'b1) begin
                    busy_ok[i] = 1'b0;
                end
            end
            if (seen[0] && seen[1] && seen[2] && seen[3]) break;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) if (done_v[i] !== 1'b0) pulse_ok[i] = 1'b0;
    endtask

    task automatic check_op(input string name, input mat_t m, input int b);
        for (int i = 0; i < 4; i++) begin
            bit any_sat;
            bit s;
            int e;
            any_sat = 1'b0;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    e = ref_q(int'(m[r][c]), b, fbits_of(i), s);
                    any_sat |= s;
                    chk($sformatf("%s dut%0d out[%0d][%0d]", name, i, r, c), out_m[i][r][c], e);
                end
            chk($sformatf("%s dut%0d latency", name, i), lat[i], exp_lat(i, b));
            chk($sformatf("%s dut%0d busy", name, i), busy_ok[i], 1);
            chk($sformatf("%s dut%0d done_pulse", name, i), pulse_ok[i], 1);
            chk($sformatf("%s dut%0d dbz", name, i), dbz_v[i], (b == 0));
            chk($sformatf("%s dut%0d ovf", name, i), ovf_v[i], (any_sat && b != 0));
        end
    endtask

    task automatic check_reset(input string name);
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    chk($sformatf("%s dut%0d out[%0d][%0d]", name, i, r, c), out_m[i][r][c], 0);
            chk($sformatf("%s dut%0d busy", name, i), busy_v[i], 0);
            chk($sformatf("%s dut%0d done", name, i), done_v[i], 0);
            chk($sformatf("%s dut%0d dbz", name, i), dbz_v[i], 0);
            chk($sformatf("%s dut%0d ovf", name, i), ovf_v[i], 0);
        end
    endtask

    initial begin
        mat_t m;
        int   b;
        logic signed [DW-1:0] rb;

        reset = 1'b1; start = 1'b0; div = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) min[r][c] = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        reset = 1'b0;

        m = '{'{10, 20, 30}, '{40, 50, 60}, '{70, 80, 90}};
        run_op(m, 3, -1);
        check_op("basic", m, 3);
        chk("basic lit out00", out_m[0][0][0], 3);
        chk("basic lit out12", out_m[0][1][2], 20);
        chk("basic lit out22", out_m[0][2][2], 30);
        chk("basic lit latency", lat[0], 54);

        m = '{'{-7, 7, -7}, '{0, 5, -5}, '{1, -1, 0}};
        run_op(m, -2, -1);
        check_op("signs", m, -2);
        chk("signs lit out00", out_m[0][0][0], 3);
        chk("signs lit out01", out_m[0][0][1], -3);

        m = '{'{1, -1, 2}, '{-2, 100, -100}, '{3, -3, 0}};
        run_op(m, 3, -1);
        check_op("frac", m, 3);
        chk("frac lit pos", out_m[1][0][0], 85);
        chk("frac lit neg", out_m[1][0][1], -85);

        m = '{'{-32768, 32767, 1}, '{-1, 0, 5}, '{-5, 300, -300}};
        run_op(m, -1, -1);
        check_op("sat_min", m, -1);
        chk("sat_min lit out00", out_m[0][0][0], 32767);
        chk("sat_min lit ovf", ovf_v[0], 1);

        m = '{'{200, -200, 127}, '{128, -129, 0}, '{1, -1, 2}};
        run_op(m, 1, -1);
        check_op("sat_frac", m, 1);
        chk("sat_frac lit out00", out_m[1][0][0], 32767);
        chk("sat_frac lit ovf", ovf_v[1], 1);

        m = '{'{5, -5, 0}, '{-32768, 32767, -1}, '{1, 100, -100}};
        run_op(m, 0, -1);
        check_op("dbz", m, 0);
        chk("dbz lit pos", out_m[0][0][0], 32767);
        chk("dbz lit neg", out_m[0][0][1], -32768);
        chk("dbz lit latency", lat[0], 6);

        m = '{'{700, -1400, 2100}, '{-2800, 3500, -4200}, '{4900, -5600, 6300}};
        run_op(m, 7, 10);
        check_op("midstart", m, 7);

        @(negedge clk);
        min = m; div = DW'(5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset("midreset");
        reset = 1'b0;

        m = '{'{1000, -2000, 3000}, '{-4000, 5000, -6000}, '{7000, -8000, 9000}};
        run_op(m, -9, -1);
        check_op("after_reset", m, -9);

        for (int t = 0; t < 20; t++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    case ($urandom_range(0, 3))
                        0:       m[r][c] = W'($urandom);
                        1:       m[r][c] = W'(int'($urandom_range(0, 200)) - 100);
                        2:       m[r][c] = -16'sd32768;
                        default: m[r][c] = 16'sd32767;
                    endcase
            rb = DW'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 0;
                1:       b = -1;
                2:       b = -128;
                default: b = int'(rb);
            endcase
            run_op(m, b, -1);
            check_op($sformatf("rand%0d", t), m, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
